// File: rtl/tournament_predictor.sv
// Tournament branch direction predictor: a bimodal table and a gshare table,
// with a per-PC chooser selecting between them. Global history (GHR) shifts
// speculatively on each prediction and rolls back on a resolved mispredict.
// Optional macro TOURNAMENT_PREDICTOR_STATS_EN enables branch/mispredict
// counters; without it both stat outputs are constant zero.
module tournament_predictor #(
  parameter int IDX_WIDTH = 6,
  parameter int GHR_WIDTH = 8,
  parameter int CNT_WIDTH = 2,
  parameter int SEL_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 pred_valid,
  input  logic [31:0]          pred_pc,
  output logic                 pred_taken,
  output logic [GHR_WIDTH-1:0] pred_ghr,
  output logic                 pred_bim,
  output logic                 pred_gsh,
  input  logic                 upd_valid,
  input  logic [31:0]          upd_pc,
  input  logic [GHR_WIDTH-1:0] upd_ghr,
  input  logic                 upd_taken,
  input  logic                 upd_bim,
  input  logic                 upd_gsh,
  input  logic                 upd_mispredict,
  output logic [31:0]          stat_branches,
  output logic [31:0]          stat_mispredicts
);

  localparam int ENTRIES = 1 << IDX_WIDTH;
  // Weakly not-taken / weakly bimodal: MSB clear, all lower bits set.
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = {1'b0, {(CNT_WIDTH-1){1'b1}}};
  localparam logic [SEL_WIDTH-1:0] SEL_INIT = {1'b0, {(SEL_WIDTH-1){1'b1}}};

  logic [CNT_WIDTH-1:0] bim_tbl [ENTRIES];
  logic [CNT_WIDTH-1:0] gsh_tbl [ENTRIES];
  logic [SEL_WIDTH-1:0] sel_tbl [ENTRIES];
  logic [GHR_WIDTH-1:0] ghr_q;

  logic [IDX_WIDTH-1:0] pred_bidx, pred_gidx, upd_bidx, upd_gidx;

  // PC bits outside the index field and the history MSB shifted out on update.
  logic unused_bits;
  assign unused_bits = ^{pred_pc[31:IDX_WIDTH+2], pred_pc[1:0],
                         upd_pc[31:IDX_WIDTH+2], upd_pc[1:0], upd_ghr[GHR_WIDTH-1]};

  function automatic logic [CNT_WIDTH-1:0] cnt_step(input logic [CNT_WIDTH-1:0] c,
                                                    input logic up);
    if (up) return (&c) ? c : c + 1'b1;
    else    return (|c) ? c - 1'b1 : c;
  endfunction

  function automatic logic [SEL_WIDTH-1:0] sel_step(input logic [SEL_WIDTH-1:0] c,
                                                    input logic up);
    if (up) return (&c) ? c : c + 1'b1;
    else    return (|c) ? c - 1'b1 : c;
  endfunction

  assign pred_bidx = pred_pc[IDX_WIDTH+1:2];
  assign pred_gidx = pred_pc[IDX_WIDTH+1:2] ^ ghr_q[IDX_WIDTH-1:0];
  assign upd_bidx  = upd_pc[IDX_WIDTH+1:2];
  assign upd_gidx  = upd_pc[IDX_WIDTH+1:2] ^ upd_ghr[IDX_WIDTH-1:0];

  // Zero-latency prediction from the current tables and history.
  always_comb begin
    pred_bim   = bim_tbl[pred_bidx][CNT_WIDTH-1];
    pred_gsh   = gsh_tbl[pred_gidx][CNT_WIDTH-1];
    pred_taken = sel_tbl[pred_bidx][SEL_WIDTH-1] ? pred_gsh : pred_bim;
    pred_ghr   = ghr_q;
  end

  // Global history: mispredict rollback has priority over speculative shift.
  always_ff @(posedge clk) begin
    if (rst)
      ghr_q <= '0;
    else if (upd_valid && upd_mispredict)
      ghr_q <= {upd_ghr[GHR_WIDTH-2:0], upd_taken};
    else if (pred_valid && !stall)
      ghr_q <= {ghr_q[GHR_WIDTH-2:0], pred_taken};
  end

  // Counter tables train on every resolved branch, independent of stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        bim_tbl[i] <= CNT_INIT;
        gsh_tbl[i] <= CNT_INIT;
        sel_tbl[i] <= SEL_INIT;
      end
    end else if (upd_valid) begin
      bim_tbl[upd_bidx] <= cnt_step(bim_tbl[upd_bidx], upd_taken);
      gsh_tbl[upd_gidx] <= cnt_step(gsh_tbl[upd_gidx], upd_taken);
      // Chooser only learns when the components disagreed.
      if (upd_bim != upd_gsh)
        sel_tbl[upd_bidx] <= sel_step(sel_tbl[upd_bidx], upd_gsh == upd_taken);
    end
  end

`ifdef TOURNAMENT_PREDICTOR_STATS_EN
  logic [31:0] stat_branches_q, stat_mispredicts_q;

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (upd_valid) begin
      if (~&stat_branches_q)
        stat_branches_q <= stat_branches_q + 32'd1;
      if (upd_mispredict && ~&stat_mispredicts_q)
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_tournament_predictor.sv
// Bench for tournament_predictor (default parameters): directed scenarios
// followed by random traffic, all checked against an array-based model.
module tb_tournament_predictor;

  logic        clk = 1'b0;
  logic        rst, stall, pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken, pred_bim, pred_gsh;
  logic [7:0]  pred_ghr;
  logic        upd_valid, upd_taken, upd_bim, upd_gsh, upd_mispredict;
  logic [31:0] upd_pc;
  logic [7:0]  upd_ghr;
  logic [31:0] stat_branches, stat_mispredicts;

  int n_assert = 0;
  int n_fail   = 0;

  int bim_m [64];
  int gsh_m [64];
  int sel_m [64];
  int ghr_m, br_m, mp_m;

  tournament_predictor #(.IDX_WIDTH(6), .GHR_WIDTH(8), .CNT_WIDTH(2), .SEL_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_ghr(pred_ghr), .pred_bim(pred_bim), .pred_gsh(pred_gsh),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
    .upd_bim(upd_bim), .upd_gsh(upd_gsh), .upd_mispredict(upd_mispredict),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      bim_m[i] = 1;
      gsh_m[i] = 1;
      sel_m[i] = 1;
    end
    ghr_m = 0;
    br_m  = 0;
    mp_m  = 0;
  endfunction

  function automatic int sat_step(input int v, input bit up);
    if (up) return (v < 3) ? v + 1 : 3;
    else    return (v > 0) ? v - 1 : 0;
  endfunction

  function automatic logic [31:0] exp_br();
`ifdef TOURNAMENT_PREDICTOR_STATS_EN
    return br_m;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_mp();
`ifdef TOURNAMENT_PREDICTOR_STATS_EN
    return mp_m;
`else
    return 0;
`endif
  endfunction

  // One clock: drive inputs, check predictions against the model, step the model.
  task automatic cyc(input bit r, input bit st, input bit pv, input logic [31:0] ppc,
                     input bit uv, input logic [31:0] upc, input logic [7:0] ughr,
                     input bit ut, input bit ub, input bit ug, input bit um);
    int bi, gi, ubi, ugi;
    bit eb, eg, et;
    rst = r; stall = st; pred_valid = pv; pred_pc = ppc;
    upd_valid = uv; upd_pc = upc; upd_ghr = ughr; upd_taken = ut;
    upd_bim = ub; upd_gsh = ug; upd_mispredict = um;
    #1;
    bi = int'((ppc >> 2) % 64);
    gi = bi ^ (ghr_m % 64);
    eb = bim_m[bi] >= 2;
    eg = gsh_m[gi] >= 2;
    et = (sel_m[bi] >= 2) ? eg : eb;
    check("pred_bim", {31'd0, pred_bim}, {31'd0, eb});
    check("pred_gsh", {31'd0, pred_gsh}, {31'd0, eg});
    check("pred_taken", {31'd0, pred_taken}, {31'd0, et});
    check("pred_ghr", {24'd0, pred_ghr}, ghr_m);
    check("stat_branches", stat_branches, exp_br());
    check("stat_mispredicts", stat_mispredicts, exp_mp());
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (uv && um)
        ghr_m = ((ughr * 2) + ut) % 256;
      else if (pv && !st)
        ghr_m = ((ghr_m * 2) + et) % 256;
      if (uv) begin
        ubi = int'((upc >> 2) % 64);
        ugi = ubi ^ (ughr % 64);
        bim_m[ubi] = sat_step(bim_m[ubi], ut);
        gsh_m[ugi] = sat_step(gsh_m[ugi], ut);
        if (ub != ug) sel_m[ubi] = sat_step(sel_m[ubi], ug == ut);
        br_m++;
        if (um) mp_m++;
      end
    end
    @(negedge clk);
  endtask

  task automatic probe(input logic [31:0] pc);
    rst = 0; stall = 0; pred_valid = 0; upd_valid = 0; upd_mispredict = 0;
    pred_pc = pc;
    #1;
  endtask

  initial begin
    rst = 1; stall = 0; pred_valid = 0; pred_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_ghr = 0; upd_taken = 0;
    upd_bim = 0; upd_gsh = 0; upd_mispredict = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 0;

    // Reset state reads zero.
    probe(32'h100);
    check("rst_taken", {31'd0, pred_taken}, 0);
    check("rst_bim", {31'd0, pred_bim}, 0);
    check("rst_gsh", {31'd0, pred_gsh}, 0);
    check("rst_ghr", {24'd0, pred_ghr}, 0);

    // Bimodal counter trains up and saturates.
    repeat (3) cyc(0, 0, 0, 32'h100, 1, 32'h100, 8'h00, 1, 0, 0, 0);
    probe(32'h100);
    check("bim_trained", {31'd0, pred_bim}, 1);

    // Four predictions, stall on the second: three zero shifts.
    cyc(0, 0, 1, 32'h104, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 32'h104, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h104, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 32'h104, 0, 0, 0, 0, 0, 0, 0);
    probe(32'h104);
    check("stall_ghr", {24'd0, pred_ghr}, 0);

    // Rollback wins over a same-cycle prediction.
    cyc(0, 0, 1, 32'h104, 1, 32'h300, 8'h5A, 1, 0, 0, 1);
    probe(32'h104);
    check("rollback_ghr", {24'd0, pred_ghr}, 32'hB5);

    // Reset overrides same-cycle update and shift.
    cyc(1, 0, 1, 32'h100, 1, 32'h100, 8'h00, 1, 1, 0, 1);
    probe(32'h100);
    check("midrst_bim", {31'd0, pred_bim}, 0);
    check("midrst_ghr", {24'd0, pred_ghr}, 0);
    check("midrst_br", stat_branches, 0);

    // Chooser saturates toward gshare; then bimodal is driven down alone.
    repeat (4) cyc(0, 0, 0, 32'h0, 1, 32'h208, 8'h00, 1, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 32'h0, 1, 32'h208, 8'h01, 0, 0, 0, 0);
    probe(32'h208);
    check("sel_bim", {31'd0, pred_bim}, 0);
    check("sel_gsh", {31'd0, pred_gsh}, 1);
    check("sel_taken", {31'd0, pred_taken}, 1);
    check("sel_counter", sel_m[2], 3);

    // Statistics: five updates, two mispredicts.
    cyc(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(0, 0, 0, 32'h0, 1, 32'h400, 8'h00, 1, 0, 0, (i == 1 || i == 3));
    probe(32'h400);
`ifdef TOURNAMENT_PREDICTOR_STATS_EN
    check("stat_br5", stat_branches, 5);
    check("stat_mp2", stat_mispredicts, 2);
`else
    check("stat_br_off", stat_branches, 0);
    check("stat_mp_off", stat_mispredicts, 0);
`endif

    // Random traffic on a small PC set so entries collide and saturate.
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1),
          32'h1000 + ($urandom_range(0, 15) << 2), ($urandom_range(0, 2) != 0),
          32'h1000 + ($urandom_range(0, 15) << 2), 8'($urandom),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
          ($urandom_range(0, 4) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tournament_predictor.md
TOURNAMENT_PREDICTOR -- requirements
Module: tournament_predictor

Interface
REQ-001 SHALL have parameter IDX_WIDTH, default 6, meaning table index bits (2^IDX_WIDTH entries per table).
REQ-002 SHALL have parameter GHR_WIDTH, default 8, meaning global history length, legal range IDX_WIDTH..16.
REQ-003 SHALL have parameter CNT_WIDTH, default 2, meaning direction counter width, legal range 2..4.
REQ-004 SHALL have parameter SEL_WIDTH, default 2, meaning chooser counter width, legal range 2..4.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port stall  input  1  pipeline stall; blocks speculative history shift.
REQ-008 SHALL have port pred_valid  input  1  a conditional branch is being predicted this cycle.
REQ-009 SHALL have port pred_pc  input  32  PC of the branch being predicted.
REQ-010 SHALL have port pred_taken  output  1  final direction prediction.
REQ-011 SHALL have port pred_ghr  output  GHR_WIDTH  history snapshot used for this prediction, carried down the pipe.
REQ-012 SHALL have port pred_bim, pred_gsh  output  1 each  component predictions, carried down the pipe.
REQ-013 SHALL have port upd_valid  input  1  resolved branch update from EX.
REQ-014 SHALL have ports upd_pc (32), upd_ghr (GHR_WIDTH), upd_taken, upd_bim, upd_gsh, upd_mispredict (1 each)  input  resolved-branch state returned from EX.
REQ-015 SHALL have ports stat_branches, stat_mispredicts  output  32 each  performance counters.

Function
REQ-016 Bimodal index SHALL be pc[IDX_WIDTH+1:2]; gshare index SHALL be pc[IDX_WIDTH+1:2] XOR ghr[IDX_WIDTH-1:0].
REQ-017 pred_bim/pred_gsh SHALL be the MSB of the indexed counters; the chooser is indexed like bimodal, and pred_taken = chooser MSB ? pred_gsh : pred_bim.
REQ-018 Prediction outputs SHALL be combinational from pred_pc and the current GHR (zero-cycle latency); pred_ghr SHALL equal the GHR before any shift.
REQ-019 On pred_valid && !stall && !(upd_valid && upd_mispredict), GHR SHALL shift to {GHR[GHR_WIDTH-2:0], pred_taken} in the next cycle.
REQ-020 On upd_valid && upd_mispredict, GHR SHALL become {upd_ghr[GHR_WIDTH-2:0], upd_taken} regardless of stall or pred_valid (rollback wins).
REQ-021 On upd_valid, bimodal[upd_pc] and gshare[upd_pc ^ upd_ghr] SHALL saturate up if upd_taken, otherwise down; they SHALL not wrap at 0 or 2^CNT_WIDTH-1.
REQ-022 On upd_valid && upd_bim != upd_gsh, the chooser SHALL saturate toward gshare if upd_gsh == upd_taken, otherwise toward bimodal; when the two components agree it SHALL be unchanged.
REQ-023 Update writes SHALL take effect the next cycle; a same-cycle prediction at the written index SHALL see the old value.
REQ-024 upd_valid SHALL not be gated by stall.

Reset
REQ-025 While rst=1, GHR SHALL clear to 0 and every direction counter SHALL reset to 2^(CNT_WIDTH-1)-1 (weakly not-taken).
REQ-026 While rst=1, every chooser SHALL reset to 2^(SEL_WIDTH-1)-1 (weakly bimodal), and stat counters SHALL clear to 0.
REQ-027 With the reset values, all outputs SHALL read 0 for any pred_pc.
REQ-028 Reset asserted mid-operation SHALL override any same-cycle update or shift.

Configuration
REQ-029 With macro TOURNAMENT_PREDICTOR_STATS_EN defined, stat_branches SHALL increment on each upd_valid and stat_mispredicts on each upd_valid && upd_mispredict, both saturating at 32'hFFFFFFFF.
REQ-030 Without TOURNAMENT_PREDICTOR_STATS_EN, both stat ports SHALL be tied to 0, and no counter registers SHALL be inferred.

Verification
REQ-031 Reset, then pred_pc=0x100 -> pred_taken=0, pred_bim=0, pred_gsh=0, pred_ghr=0.
REQ-032 Three upd_valid with upd_pc=0x100, upd_taken=1, upd_ghr=0 -> bimodal counter reaches 3 (2-bit); pred_bim=1 at pc 0x100 with GHR 0.
REQ-033 pred_valid on 4 consecutive cycles with pred_taken=0 and stall high on the 2nd cycle -> GHR shifts 3 times; the final pred_ghr equals 0.
REQ-034 Same cycle: pred_valid=1 and upd_mispredict=1, upd_ghr=8'h5A, upd_taken=1 -> next-cycle GHR=8'hB5.
REQ-035 Repeated updates with upd_bim=0, upd_gsh=1, upd_taken=1 -> chooser saturates at 3; pred_taken follows pred_gsh.
REQ-036 Stats enabled: 5 updates including 2 mispredicts -> stat_branches=5, stat_mispredicts=2; with the macro undefined -> both read 0.
